uib_arb: RTL and testbench

Parametrised, registered successor to the single-path uib interconnect. It connects N_MASTER masters to N_SLAVE slaves through one shared transaction path. Competing requests are resolved by round-robin arbitration. Accesses to unmapped slave numbers, and slaves that never answer, are terminated with an error response. It sits at the top level between cpu/DMA-style masters and mainmem, uart, timer and future slaves.

---
 rtl/uib_pkg.sv | 23 ++
 rtl/uib_rr_arbiter.sv | 30 +++
 rtl/uib_arb.sv | 228 ++++++++++++++++++++++
 tb/tb_uib_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uib_pkg.sv
// Shared definitions for the uib interconnect: bus defaults, FSM state codes
// and access-mode encodings understood by cpu and slaves.
package uib_pkg;

  localparam int unsigned UIB_XLEN        = 32;
  localparam int unsigned UIB_SLAVE_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Bit 2 selects zero-extension; bits 1:0 select size.
  localparam logic [2:0] MODE_BYTE  = 3'b000;
  localparam logic [2:0] MODE_HALF  = 3'b001;
  localparam logic [2:0] MODE_WORD  = 3'b010;
  localparam logic [2:0] MODE_BYTEU = 3'b100;
  localparam logic [2:0] MODE_HALFU = 3'b101;

  function automatic logic mode_is_unsigned(input logic [2:0] mode);
    return mode[2];
  endfunction

endpackage

// File: rtl/uib_rr_arbiter.sv
// Round-robin grant: first requester at or after last_grant+1 (mod N).
module uib_rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_oh_c,
  output logic [IW-1:0] grant_idx_c,
  output logic          grant_vld_c
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    cand        = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(last_grant) + i) % N);
      if (!grant_vld_c && req[cand]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand;
      end
    end
    if (grant_vld_c) grant_oh_c[grant_idx_c] = 1'b1;
  end

endmodule

// File: rtl/uib_arb.sv
// N-master to N-slave registered interconnect with one shared transaction
// path, round-robin arbitration, decode-error and timeout termination.
module uib_arb
  import uib_pkg::*;
#(
  parameter int unsigned N_MASTER    = 2,
  parameter int unsigned N_SLAVE     = 4,
  parameter int unsigned XLEN        = UIB_XLEN,
  parameter int unsigned SLAVE_WIDTH = UIB_SLAVE_WIDTH,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [N_MASTER-1:0][XLEN-1:0]                    master_dat_o,
  input  logic [N_MASTER-1:0][XLEN-SLAVE_WIDTH-1:0]        master_addr,
  input  logic [N_MASTER-1:0][SLAVE_WIDTH-1:0]             master_num,
  input  logic [N_MASTER-1:0][2:0]                         master_mode,
  input  logic [N_MASTER-1:0]                              master_wen,
  input  logic [N_MASTER-1:0]                              master_req,
  output logic [N_MASTER-1:0][XLEN-1:0]                    master_dat_i,
  output logic [N_MASTER-1:0]                              master_ready,
  output logic [N_MASTER-1:0]                              master_err,
  output logic [N_SLAVE-1:0][XLEN-1:0]                     slave_dat_i,
  output logic [N_SLAVE-1:0][XLEN-SLAVE_WIDTH-1:0]         slave_addr,
  output logic [N_SLAVE-1:0][2:0]                          slave_mode,
  output logic [N_SLAVE-1:0]                               slave_wen,
  output logic [N_SLAVE-1:0]                               slave_req,
  input  logic [N_SLAVE-1:0][XLEN-1:0]                     slave_dat_o,
  input  logic [N_SLAVE-1:0]                               slave_ready
);

  localparam int unsigned AW = XLEN - SLAVE_WIDTH;
  localparam int unsigned GW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [1:0]             state_q, state_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [SLAVE_WIDTH-1:0] num_q, num_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [N_SLAVE-1:0]               slave_req_q, slave_req_d;
  logic [N_SLAVE-1:0]               slave_wen_q, slave_wen_d;
  logic [N_SLAVE-1:0][AW-1:0]       slave_addr_q, slave_addr_d;
  logic [N_SLAVE-1:0][2:0]          slave_mode_q, slave_mode_d;
  logic [N_SLAVE-1:0][XLEN-1:0]     slave_dat_i_q, slave_dat_i_d;
  logic [N_MASTER-1:0]              master_ready_q, master_ready_d;
  logic [N_MASTER-1:0]              master_err_q, master_err_d;
  logic [N_MASTER-1:0][XLEN-1:0]    master_dat_i_q, master_dat_i_d;

  logic [N_MASTER-1:0]    arb_oh_c;
  logic [GW-1:0]          arb_idx_c;
  logic                   arb_vld_c;
  logic [SLAVE_WIDTH-1:0] sel_num_c;
  logic [AW-1:0]          sel_addr_c;
  logic [2:0]             sel_mode_c;
  logic                   sel_wen_c;
  logic [XLEN-1:0]        sel_dat_c;
  logic                   slv_rdy_c;
  logic [XLEN-1:0]        slv_dat_c;
  logic                   resp_v;
  logic                   resp_err;
  logic [XLEN-1:0]        resp_dat;
  logic [GW-1:0]          resp_m;

  uib_rr_arbiter #(.N(N_MASTER)) u_rr (
    .req         (master_req),
    .last_grant  (last_grant_q),
    .grant_oh_c  (arb_oh_c),
    .grant_idx_c (arb_idx_c),
    .grant_vld_c (arb_vld_c)
  );

  // Request fields of the winning master.
  always_comb begin
    sel_num_c  = '0;
    sel_addr_c = '0;
    sel_mode_c = '0;
    sel_wen_c  = 1'b0;
    sel_dat_c  = '0;
    for (int unsigned m = 0; m < N_MASTER; m++) begin
      if (arb_oh_c[m]) begin
        sel_num_c  = master_num[m];
        sel_addr_c = master_addr[m];
        sel_mode_c = master_mode[m];
        sel_wen_c  = master_wen[m];
        sel_dat_c  = master_dat_o[m];
      end
    end
  end

  // Response of the slave owning the current transaction.
  always_comb begin
    slv_rdy_c = 1'b0;
    slv_dat_c = '0;
    for (int unsigned s = 0; s < N_SLAVE; s++) begin
      if (32'(num_q) == s) begin
        slv_rdy_c = slave_ready[s];
        slv_dat_c = slave_dat_o[s];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    num_d          = num_q;
    cnt_d          = cnt_q;
    slave_req_d    = slave_req_q;
    slave_wen_d    = slave_wen_q;
    slave_addr_d   = slave_addr_q;
    slave_mode_d   = slave_mode_q;
    slave_dat_i_d  = slave_dat_i_q;
    master_ready_d = '0;
    master_err_d   = '0;
    master_dat_i_d = master_dat_i_q;
    resp_v         = 1'b0;
    resp_err       = 1'b0;
    resp_dat       = '0;
    resp_m         = grant_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_vld_c) begin
          grant_d      = arb_idx_c;
          last_grant_d = arb_idx_c;
          num_d        = sel_num_c;
          resp_m       = arb_idx_c;
          if (32'(sel_num_c) >= N_SLAVE) begin
            state_d  = ST_RESP;
            resp_v   = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CW'(1);
            for (int unsigned s = 0; s < N_SLAVE; s++) begin
              if (32'(sel_num_c) == s) begin
                slave_req_d[s]   = 1'b1;
                slave_wen_d[s]   = sel_wen_c;
                slave_addr_d[s]  = sel_addr_c;
                slave_mode_d[s]  = sel_mode_c;
                slave_dat_i_d[s] = sel_dat_c;
              end
            end
          end
        end
      end
      ST_BUSY: begin
        // A ready on the final tolerated cycle still beats the timeout.
        if (slv_rdy_c) begin
          resp_v   = 1'b1;
          resp_dat = slv_dat_c;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          resp_v   = 1'b1;
          resp_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (resp_v) begin
          state_d       = ST_RESP;
          slave_req_d   = '0;
          slave_wen_d   = '0;
          slave_addr_d  = '0;
          slave_mode_d  = '0;
          slave_dat_i_d = '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (resp_v) begin
      for (int unsigned m = 0; m < N_MASTER; m++) begin
        if (resp_m == GW'(m)) begin
          master_ready_d[m] = 1'b1;
          master_err_d[m]   = resp_err;
          master_dat_i_d[m] = resp_dat;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GW'(N_MASTER - 1);
      grant_q        <= '0;
      num_q          <= '0;
      cnt_q          <= '0;
      slave_req_q    <= '0;
      slave_wen_q    <= '0;
      slave_addr_q   <= '0;
      slave_mode_q   <= '0;
      slave_dat_i_q  <= '0;
      master_ready_q <= '0;
      master_err_q   <= '0;
      master_dat_i_q <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      num_q          <= num_d;
      cnt_q          <= cnt_d;
      slave_req_q    <= slave_req_d;
      slave_wen_q    <= slave_wen_d;
      slave_addr_q   <= slave_addr_d;
      slave_mode_q   <= slave_mode_d;
      slave_dat_i_q  <= slave_dat_i_d;
      master_ready_q <= master_ready_d;
      master_err_q   <= master_err_d;
      master_dat_i_q <= master_dat_i_d;
    end
  end

  assign slave_req    = slave_req_q;
  assign slave_wen    = slave_wen_q;
  assign slave_addr   = slave_addr_q;
  assign slave_mode   = slave_mode_q;
  assign slave_dat_i  = slave_dat_i_q;
  assign master_ready = master_ready_q;
  assign master_err   = master_err_q;
  assign master_dat_i = master_dat_i_q;

endmodule

// File: tb/tb_uib_arb.sv
// Bench for uib_arb: directed scenarios plus randomized traffic, checked each
// cycle against a timestamp-based transaction model.
module tb_uib_arb;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int XL = 32;
  localparam int SW = 4;
  localparam int TO = 8;
  localparam int AW = XL - SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NM-1:0][XL-1:0] master_dat_o = '0;
  logic [NM-1:0][AW-1:0] master_addr = '0;
  logic [NM-1:0][SW-1:0] master_num = '0;
  logic [NM-1:0][2:0]    master_mode = '0;
  logic [NM-1:0]         master_wen = '0;
  logic [NM-1:0]         master_req = '0;
  logic [NM-1:0][XL-1:0] master_dat_i;
  logic [NM-1:0]         master_ready;
  logic [NM-1:0]         master_err;
  logic [NS-1:0][XL-1:0] slave_dat_i;
  logic [NS-1:0][AW-1:0] slave_addr;
  logic [NS-1:0][2:0]    slave_mode;
  logic [NS-1:0]         slave_wen;
  logic [NS-1:0]         slave_req;
  logic [NS-1:0][XL-1:0] slave_dat_o = '0;
  logic [NS-1:0]         slave_ready = '0;

  uib_arb #(.N_MASTER(NM), .N_SLAVE(NS), .XLEN(XL), .SLAVE_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .master_dat_o(master_dat_o), .master_addr(master_addr), .master_num(master_num),
    .master_mode(master_mode), .master_wen(master_wen), .master_req(master_req),
    .master_dat_i(master_dat_i), .master_ready(master_ready), .master_err(master_err),
    .slave_dat_i(slave_dat_i), .slave_addr(slave_addr), .slave_mode(slave_mode),
    .slave_wen(slave_wen), .slave_req(slave_req),
    .slave_dat_o(slave_dat_o), .slave_ready(slave_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model: edges are numbered; a granted transaction either answers on the
  // next edge (unmapped) or keeps its slave window open until ready or TO edges.
  int e = 0;
  int free_at = 0;
  bit open = 1'b0;
  int open_edge = 0;
  int cur_m = 0;
  int cur_s = 0;
  int last_g = NM - 1;
  bit granted [NM];
  logic [NS-1:0]         x_sreq, x_swen;
  logic [NS-1:0][AW-1:0] x_saddr;
  logic [NS-1:0][2:0]    x_smode;
  logic [NS-1:0][XL-1:0] x_sdat;
  logic [NM-1:0]         x_mrdy, x_merr;
  logic [NM-1:0][XL-1:0] x_mdat;

  function automatic void finish_txn(input bit er, input logic [XL-1:0] d);
    open = 1'b0;
    x_sreq = '0; x_swen = '0; x_saddr = '0; x_smode = '0; x_sdat = '0;
    x_mrdy[cur_m] = 1'b1;
    x_merr[cur_m] = er;
    x_mdat[cur_m] = er ? '0 : d;
    granted[cur_m] = 1'b0;
    free_at = e + 2;
  endfunction

  always @(posedge clk) begin
    bit found;
    e++;
    x_mrdy = '0;
    x_merr = '0;
    if (rst) begin
      open = 1'b0; last_g = NM - 1; free_at = e + 1;
      x_sreq = '0; x_swen = '0; x_saddr = '0; x_smode = '0; x_sdat = '0;
      x_mdat = '0;
      for (int m = 0; m < NM; m++) granted[m] = 1'b0;
    end else if (open) begin
      if (slave_ready[cur_s]) finish_txn(1'b0, slave_dat_o[cur_s]);
      else if (e - open_edge == TO) finish_txn(1'b1, '0);
    end else if (e >= free_at && master_req != '0) begin
      found = 1'b0;
      for (int i = 1; i <= NM; i++) begin
        if (!found && master_req[(last_g + i) % NM]) begin
          found = 1'b1;
          cur_m = (last_g + i) % NM;
        end
      end
      last_g = cur_m;
      granted[cur_m] = 1'b1;
      cur_s = int'(master_num[cur_m]);
      if (cur_s >= NS) begin
        finish_txn(1'b1, '0);
      end else begin
        open = 1'b1;
        open_edge = e;
        x_sreq[cur_s]  = 1'b1;
        x_swen[cur_s]  = master_wen[cur_m];
        x_saddr[cur_s] = master_addr[cur_m];
        x_smode[cur_s] = master_mode[cur_m];
        x_sdat[cur_s]  = master_dat_o[cur_m];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("slave_req", 256'(slave_req), 256'(x_sreq));
      chk("slave_wen", 256'(slave_wen), 256'(x_swen));
      chk("slave_addr", 256'(slave_addr), 256'(x_saddr));
      chk("slave_mode", 256'(slave_mode), 256'(x_smode));
      chk("slave_dat_i", 256'(slave_dat_i), 256'(x_sdat));
      chk("master_ready", 256'(master_ready), 256'(x_mrdy));
      chk("master_err", 256'(master_err), 256'(x_merr));
      chk("master_dat_i", 256'(master_dat_i), 256'(x_mdat));
    end
  end

  // Issue one request and follow it until the master's ready pulse.
  task automatic txn(input int m, input int s, input logic [AW-1:0] a, input logic w,
                     input logic [2:0] md, input logic [XL-1:0] wd,
                     output int lat, output int reqc, output logic er,
                     output logic [XL-1:0] rd, output bit fwd_ok);
    bit done;
    master_num[m] = SW'(s); master_addr[m] = a; master_wen[m] = w;
    master_mode[m] = md; master_dat_o[m] = wd; master_req[m] = 1'b1;
    lat = 0; reqc = 0; er = 1'b0; rd = '0; fwd_ok = 1'b1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (s < NS && slave_req[s]) begin
        reqc++;
        if (slave_dat_i[s] !== wd || slave_wen[s] !== w || slave_mode[s] !== md ||
            slave_addr[s] !== a) fwd_ok = 1'b0;
      end
      if (master_ready[m]) begin
        er = master_err[m];
        rd = master_dat_i[m];
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    master_req[m] = 1'b0;
  endtask

  int lat, reqc;
  logic er;
  logic [XL-1:0] rd;
  bit fwd_ok;
  int order [4];
  int np;
  logic [3:0] ord_bits;
  bit act [NM];
  bit seen;

  initial begin
    @(posedge clk); #2;
    chk("reset_slave_req", 256'(slave_req), 256'(0));
    chk("reset_master_ready", 256'(master_ready), 256'(0));
    chk("reset_master_dat_i", 256'(master_dat_i), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk_on = 1'b1;

    // Single read, slave 0 ready on its first request cycle.
    slave_ready[0] = 1'b1; slave_dat_o[0] = 32'hDEADBEEF;
    txn(0, 0, 28'h10, 1'b0, 3'b010, 32'h0, lat, reqc, er, rd, fwd_ok);
    chk("read_latency", 256'(lat), 256'(3));
    chk("read_data", 256'(rd), 256'(32'hDEADBEEF));
    chk("read_err", 256'(er), 256'(0));

    // Unmapped slave number.
    repeat (2) @(posedge clk); #1;
    txn(1, 4, 28'h20, 1'b0, 3'b010, 32'h0, lat, reqc, er, rd, fwd_ok);
    chk("decode_latency", 256'(lat), 256'(2));
    chk("decode_err", 256'(er), 256'(1));
    chk("decode_data", 256'(rd), 256'(0));
    chk("decode_no_req", 256'(reqc), 256'(0));

    // Slave 2 never answers.
    repeat (2) @(posedge clk); #1;
    slave_ready = '0;
    txn(0, 2, 28'h30, 1'b0, 3'b010, 32'h0, lat, reqc, er, rd, fwd_ok);
    chk("timeout_req_cycles", 256'(reqc), 256'(TO));
    chk("timeout_latency", 256'(lat), 256'(TO + 2));
    chk("timeout_err", 256'(er), 256'(1));
    chk("timeout_data", 256'(rd), 256'(0));

    // Write to slave 3 after the timeout; read data still captured.
    repeat (2) @(posedge clk); #1;
    slave_ready[3] = 1'b1; slave_dat_o[3] = 32'hCAFE0003;
    txn(1, 3, 28'h44, 1'b1, 3'b010, 32'h12345678, lat, reqc, er, rd, fwd_ok);
    chk("write_forward", 256'(fwd_ok), 256'(1));
    chk("write_req_cycles", 256'(reqc), 256'(1));
    chk("write_latency", 256'(lat), 256'(3));
    chk("write_rdata", 256'(rd), 256'(32'hCAFE0003));
    chk("write_err", 256'(er), 256'(0));

    // Both masters request continuously.
    repeat (2) @(posedge clk); #1;
    slave_ready = '1;
    master_num[0] = 4'd0; master_num[1] = 4'd1; master_wen = '0;
    master_req = 2'b11;
    np = 0;
    for (int i = 0; i < 4; i++) order[i] = 0;
    for (int i = 0; i < 60 && np < 4; i++) begin
      @(negedge clk);
      for (int m = 0; m < NM; m++) if (master_ready[m] && np < 4) begin order[np] = m; np++; end
    end
    @(posedge clk); #1;
    master_req = '0;
    for (int i = 0; i < 4; i++) ord_bits[i] = order[i][0];
    chk("rr_pulses", 256'(np), 256'(4));
    chk("rr_order", 256'(ord_bits), 256'(4'b1010));

    // Reset while master 0 has slave 1 in BUSY.
    repeat (2) @(posedge clk); #1;
    slave_ready = '0;
    master_num[0] = 4'd1; master_req[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (slave_req[1]) seen = 1'b1;
    end
    chk("pre_reset_busy", 256'(seen), 256'(1));
    #1 rst = 1'b1;
    #1;
    chk("async_slave_req", 256'(slave_req), 256'(0));
    chk("async_slave_dat", 256'(slave_dat_i), 256'(0));
    chk("async_master_rdy", 256'(master_ready), 256'(0));
    chk("async_master_dat", 256'(master_dat_i), 256'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    master_num[0] = 4'd0; master_num[1] = 4'd1;
    slave_ready = '1;
    master_req = 2'b11;
    np = -1;
    for (int i = 0; i < 20 && np < 0; i++) begin
      @(negedge clk);
      for (int m = NM - 1; m >= 0; m--) if (master_ready[m]) np = m;
    end
    chk("first_grant_after_reset", 256'(np), 256'(0));
    @(posedge clk); #1;
    master_req = '0;

    // Randomized traffic: mixed slaves, unmapped numbers, slow slave 2.
    for (int m = 0; m < NM; m++) act[m] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < NS; s++) begin
        slave_ready[s] = (s == 2) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
        slave_dat_o[s] = $urandom;
      end
      for (int m = 0; m < NM; m++) begin
        if (act[m] && x_mrdy[m]) begin
          act[m] = 1'b0;
          master_req[m] = 1'b0;
        end
        if (!act[m]) begin
          if ($urandom_range(0, 2) == 0) begin
            act[m] = 1'b1;
            master_req[m] = 1'b1;
            master_num[m] = SW'($urandom_range(0, 5));
            master_addr[m] = AW'($urandom);
            master_wen[m] = 1'($urandom_range(0, 1));
            master_mode[m] = 3'($urandom_range(0, 7));
            master_dat_o[m] = $urandom;
          end
        end else if (granted[m] && master_req[m] && $urandom_range(0, 7) == 0) begin
          master_req[m] = 1'b0;
        end
      end
    end
    master_req = '0;
    repeat (TO + 4) @(posedge clk);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
